adder_arbiter: RTL and testbench

//  Shares one 32-bit combinational adder among NUM_REQ requesters, e.g. PC+4,

---
 rtl/adder_arbiter.sv | 140 ++++++++++++++
 tb/tb_adder_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : adder_arbiter
//  Description : Round-robin arbiter that shares one combinational adder among
//                NUM_REQ valid/ready requesters. The sum is registered together
//                with the winner's ID and held until the consumer accepts it.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                req_valid/ready    - per-requester handshake (ready one-hot)
//                req_a/req_b        - packed operands, requester i at [i*WIDTH +: WIDTH]
//                add_a/add_b        - operands driven to the shared adder
//                add_out            - sum returned from the shared adder
//                rsp_valid/ready    - result handshake
//                rsp_data/id/ovf    - registered sum, winner index, signed overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_arbiter #(
   parameter int WIDTH   = 32,
   parameter int NUM_REQ = 3,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*WIDTH-1:0]   req_b,
   output logic [WIDTH-1:0]           add_a,
   output logic [WIDTH-1:0]           add_b,
   input  logic [WIDTH-1:0]           add_out,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [WIDTH-1:0]           rsp_data,
   output logic [ID_W-1:0]            rsp_id,
   output logic                       rsp_ovf
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_HOLD = 1'b1;

   logic [0:0]       state_q,    state_d;
   logic [ID_W-1:0]  rr_ptr_q,   rr_ptr_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic [ID_W-1:0]  rsp_id_q,   rsp_id_d;
   logic             rsp_ovf_q,  rsp_ovf_d;

   logic             can_issue;
   logic             found;
   logic             grant;
   logic [ID_W-1:0]  winner;
   logic             sum_ovf;

   // A held result may be replaced in the same cycle it is being drained.
   assign can_issue = (state_q == S_IDLE) | rsp_ready;

   // Winner = valid requester with the smallest circular distance from rr_ptr.
   always_comb begin
      int best;
      int d;
      best   = NUM_REQ;
      d      = 0;
      winner = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         d = i - int'(rr_ptr_q);
         if (d < 0) begin
            d = d + NUM_REQ;
         end
         if (req_valid[i] && (d < best)) begin
            best   = d;
            winner = ID_W'(i);
         end
      end
      found = (best < NUM_REQ);
   end

   // Reset blocks grants so nothing is handshaken while the core is cleared.
   assign grant = can_issue & found & ~rst;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
         assign req_ready[gi] = grant & (winner == ID_W'(gi));
      end
   endgenerate

   // Operands are zero without a grant so the adder never sees stale data.
   always_comb begin
      add_a = '0;
      add_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_ready[i]) begin
            add_a = req_a[i*WIDTH +: WIDTH];
            add_b = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   // Signed overflow: like-signed operands producing a differently-signed sum.
   assign sum_ovf = (add_a[WIDTH-1] == add_b[WIDTH-1]) &
                    (add_out[WIDTH-1] != add_a[WIDTH-1]);

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      rsp_data_d = rsp_data_q;
      rsp_id_d   = rsp_id_q;
      rsp_ovf_d  = rsp_ovf_q;
      if (grant) begin
         state_d    = S_HOLD;
         rsp_data_d = add_out;
         rsp_id_d   = winner;
         rsp_ovf_d  = sum_ovf;
         rr_ptr_d   = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
      end else if ((state_q == S_HOLD) && rsp_ready) begin
         // Drain only; payload keeps its last value.
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         rsp_data_q <= '0;
         rsp_id_q   <= '0;
         rsp_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         rsp_data_q <= rsp_data_d;
         rsp_id_q   <= rsp_id_d;
         rsp_ovf_q  <= rsp_ovf_d;
      end
   end

   assign rsp_valid = (state_q == S_HOLD);
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_ovf   = rsp_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_arbiter
//  Description : Self-checking bench for adder_arbiter. A behavioural model
//                tracks the result register and round-robin pointer; directed
//                vectors add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_arbiter;

   localparam int W    = 32;
   localparam int N    = 3;
   localparam int ID_W = $clog2(N);

   logic               clk = 1'b0;
   logic               rst;
   logic [N-1:0]       req_valid;
   logic [N-1:0]       req_ready;
   logic [N*W-1:0]     req_a;
   logic [N*W-1:0]     req_b;
   logic [W-1:0]       add_a;
   logic [W-1:0]       add_b;
   logic [W-1:0]       add_out;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [W-1:0]       rsp_data;
   logic [ID_W-1:0]    rsp_id;
   logic               rsp_ovf;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   // The shared adder lives outside the arbiter.
   assign add_out = add_a + add_b;

   adder_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_out   (add_out),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .rsp_ovf   (rsp_ovf)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic          m_known = 1'b0;
   logic          m_valid;
   logic [W-1:0]  m_data;
   int            m_id;
   logic          m_ovf;
   int            m_ptr;

   always @(negedge clk) begin
      logic         e_grant;
      int           e_w;
      logic [W-1:0] e_a;
      logic [W-1:0] e_b;
      logic [W-1:0] e_sum;
      logic [N-1:0] e_rdy;
      e_grant = 1'b0;
      e_w     = 0;
      if (!rst && (!m_valid || rsp_ready || !m_known)) begin
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (!e_grant && req_valid[idx]) begin
               e_grant = 1'b1;
               e_w     = idx;
            end
         end
      end
      e_rdy = '0;
      e_a   = '0;
      e_b   = '0;
      if (e_grant) begin
         e_rdy[e_w] = 1'b1;
         e_a        = req_a[e_w*W +: W];
         e_b        = req_b[e_w*W +: W];
      end
      e_sum = e_a + e_b;
      if (m_known) begin
         check("model req_ready", 64'(req_ready), 64'(e_rdy));
         check("model add_a",     64'(add_a),     64'(e_a));
         check("model add_b",     64'(add_b),     64'(e_b));
         check("model rsp_valid", 64'(rsp_valid), 64'(m_valid));
         check("model rsp_data",  64'(rsp_data),  64'(m_data));
         check("model rsp_id",    64'(rsp_id),    64'(m_id));
         check("model rsp_ovf",   64'(rsp_ovf),   64'(m_ovf));
      end
      // State after the coming posedge.
      if (rst) begin
         m_known = 1'b1;
         m_valid = 1'b0;
         m_data  = '0;
         m_id    = 0;
         m_ovf   = 1'b0;
         m_ptr   = 0;
      end else if (m_known) begin
         if (e_grant) begin
            m_valid = 1'b1;
            m_data  = e_sum;
            m_id    = e_w;
            m_ovf   = ($signed(e_a) >= 0) == ($signed(e_b) >= 0) &&
                      (($signed(e_sum) >= 0) != ($signed(e_a) >= 0));
            m_ptr   = (e_w + 1) % N;
         end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 3'b111;
      rsp_ready = 1'b0;
      req_a     = '0;
      req_b     = '0;
      for (int i = 0; i < N; i++) set_op(i, W'(100 * (i + 1)), W'(i + 1));

      // 1. reset with all requests valid
      @(negedge clk);
      check("reset ready c1", 64'(req_ready), 64'(0));
      tick();
      @(negedge clk);
      check("reset ready c2", 64'(req_ready), 64'(0));
      tick();
      rst       = 1'b0;
      req_valid = '0;
      @(negedge clk);
      check("post-reset rsp_valid", 64'(rsp_valid), 64'(0));
      check("post-reset rsp_data",  64'(rsp_data),  64'(0));

      // 2. single request
      tick();
      set_op(0, 32'd5, 32'd7);
      req_valid = 3'b001;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("single ready", 64'(req_ready), 64'(3'b001));
      check("single add_a", 64'(add_a), 64'(5));
      tick();
      req_valid = '0;
      @(negedge clk);
      check("single rsp_valid", 64'(rsp_valid), 64'(1));
      check("single rsp_data",  64'(rsp_data),  64'(12));
      check("single rsp_id",    64'(rsp_id),    64'(0));
      check("single rsp_ovf",   64'(rsp_ovf),   64'(0));

      // Move the pointer back to 0 via requester 2.
      tick();
      req_valid = 3'b100;
      @(negedge clk);
      check("rotate ready r2", 64'(req_ready), 64'(3'b100));

      // 3. round-robin with all requesters valid
      for (int i = 0; i < N; i++) set_op(i, W'(100 * (i + 1)), W'(i + 1));
      tick();
      req_valid = 3'b111;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("rr grant", 64'(req_ready), 64'(3'b001 << (k % 3)));
         if (k > 0) check("rr rsp_id", 64'(rsp_id), 64'((k - 1) % 3));
         if (k < 5) tick();
      end

      // 4. backpressure: last result is requester 2 (300+3)
      tick();
      req_valid = 3'b010;
      rsp_ready = 1'b0;
      set_op(1, 32'hDEAD0000, 32'h0000BEEF);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("bp ready",    64'(req_ready), 64'(0));
         check("bp rsp_data", 64'(rsp_data),  64'(303));
         check("bp rsp_id",   64'(rsp_id),    64'(2));
         if (k < 3) tick();
      end
      tick();
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp release grant", 64'(req_ready), 64'(3'b010));
      tick();
      req_valid = '0;
      @(negedge clk);
      check("bp new data", 64'(rsp_data), 64'(32'hDEADBEEF));
      check("bp new id",   64'(rsp_id),   64'(1));

      // 5. wrap / overflow
      tick();
      req_valid = 3'b001;
      set_op(0, 32'h7FFFFFFF, 32'h1);
      @(negedge clk);
      check("ovf ready", 64'(req_ready), 64'(3'b001));
      tick();
      set_op(0, 32'hFFFFFFFF, 32'h1);
      @(negedge clk);
      check("ovf pos data", 64'(rsp_data), 64'(32'h80000000));
      check("ovf pos flag", 64'(rsp_ovf),  64'(1));
      tick();
      set_op(0, 32'h80000000, 32'h80000000);
      @(negedge clk);
      check("wrap data", 64'(rsp_data), 64'(0));
      check("wrap flag", 64'(rsp_ovf),  64'(0));
      tick();
      req_valid = '0;
      rsp_ready = 1'b0;
      @(negedge clk);
      check("ovf neg data", 64'(rsp_data), 64'(0));
      check("ovf neg flag", 64'(rsp_ovf),  64'(1));

      // 6. reset while holding a result (pointer currently at 1)
      tick();
      rst       = 1'b1;
      req_valid = 3'b111;
      @(negedge clk);
      check("midrst ready", 64'(req_ready), 64'(0));
      tick();
      rst       = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("midrst rsp_valid", 64'(rsp_valid), 64'(0));
      check("midrst grant r0",  64'(req_ready), 64'(3'b001));
      tick();
      req_valid = '0;
      @(negedge clk);
      check("midrst rsp_id",    64'(rsp_id),    64'(0));
      check("midrst rsp_valid", 64'(rsp_valid), 64'(1));
      tick();
      tick();
      @(negedge clk);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
